// File: rtl/pipe_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_muldiv_iter
// Purpose  : Iterative MULT/MULTU/DIV/DIVU unit that sits beside the EXE ALU.
//            Accepts one operation, iterates one bit per cycle (shift-add
//            multiply, restoring divide) on operand magnitudes, applies the
//            sign correction in a final FIX cycle and returns a HI/LO pair.
//            The pipeline stalls while busy_o is high; HI/LO are written on
//            done_o.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            start_i, op_i    - request + opcode (00 MULTU, 01 MULT,
//                               10 DIVU, 11 DIV), sampled when busy_o=0
//            a_i, b_i         - rs (multiplicand/dividend), rt (multiplier/
//                               divisor)
//            flush_i          - abort the operation in flight
//            busy_o, done_o   - stall request, one-cycle result strobe
//            hi_o, lo_o       - MUL: product high/low; DIV: remainder/quotient
//            div_zero_o       - qualifies done_o: divisor was zero
// Options  : MULDIV_EARLY_OUT_EN - finish a multiply as soon as the remaining
//            multiplier bits are all zero (divide latency unchanged).
// Revision : 1.0 - initial release
// ============================================================================
module pipe_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sign_lo_q, sign_lo_d;   // product / quotient sign
  logic             sign_hi_q, sign_hi_d;   // remainder sign (dividend sign)
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;     // MUL: upper acc; DIV: remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;     // MUL: multiplier/lower; DIV: quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // ---------------------------------------------------------------- decode
  logic             w_op_div;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_op_div = op_i[1];
  assign w_a_neg  = op_i[0] & a_i[WIDTH-1];
  assign w_b_neg  = op_i[0] & b_i[WIDTH-1];
  // The magnitude of the most negative value is its own unsigned bit pattern,
  // which is exactly what the unsigned iterators need.
  assign w_a_mag  = w_a_neg ? -a_i : a_i;
  assign w_b_mag  = w_b_neg ? -b_i : b_i;

  // ---------------------------------------------------------- multiply step
  // Add the multiplicand into the upper half when the multiplier LSB is set,
  // then shift {carry, acc_hi, acc_lo} right by one.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;

  assign w_mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // ------------------------------------------------------------ divide step
  // Shift {rem, quo} left one; keep the trial difference when it is >= 0.
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_rem;
  logic [WIDTH-1:0] w_div_quo;

  assign w_div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign w_div_ge  = (w_div_sh >= {1'b0, opnd_q});
  // When w_div_ge holds the difference is below 2^WIDTH, so the low bits are exact.
  assign w_div_rem = w_div_ge ? (w_div_sh[WIDTH-1:0] - opnd_q) : w_div_sh[WIDTH-1:0];
  assign w_div_quo = {acc_lo_q[WIDTH-2:0], w_div_ge};

  // ------------------------------------------------------- sign correction
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_prod     = {acc_hi_q, acc_lo_q};
  assign w_prod_fix = sign_lo_q ? -w_prod : w_prod;
  // MIN / -1: magnitudes give quotient 2^(WIDTH-1) with a positive sign,
  // which already reads back as MIN with remainder 0.
  assign w_quo_fix  = sign_lo_q ? -acc_lo_q : acc_lo_q;
  assign w_rem_fix  = sign_hi_q ? -acc_hi_q : acc_hi_q;

  logic [CNT_W-1:0] w_cnt_next;
  assign w_cnt_next = cnt_q - c_cnt_one;

`ifdef MULDIV_EARLY_OUT_EN
  // After this iteration the unconsumed multiplier bits sit in the low
  // w_cnt_next bits of acc_lo. If they are all zero, the remaining
  // iterations would only shift, so do all of that shift at once.
  logic [WIDTH-1:0]   w_mul_rem_mask;
  logic               w_mul_early;
  logic [2*WIDTH-1:0] w_mul_align;

  assign w_mul_rem_mask = ~({WIDTH{1'b1}} << w_cnt_next);
  assign w_mul_early    = ((w_mul_lo & w_mul_rem_mask) == '0) && (w_cnt_next != '0);
  assign w_mul_align    = {w_mul_hi, w_mul_lo} >> w_cnt_next;
`endif

  // ------------------------------------------------ next-state / datapath
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sign_lo_d = sign_lo_q;
    sign_hi_d = sign_hi_q;
    dz_d      = dz_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          is_div_d  = w_op_div;
          sign_lo_d = w_a_neg ^ w_b_neg;
          sign_hi_d = w_a_neg;
          dz_d      = 1'b0;
          acc_hi_d  = '0;
          cnt_d     = c_cnt_full;
          state_d   = S_RUN;
          if (w_op_div) begin
            opnd_d   = w_b_mag;
            acc_lo_d = w_a_mag;
            if (b_i == '0) begin
              // Divide by zero bypasses the iterations; FIX reports raw a_i.
              dz_d     = 1'b1;
              acc_hi_d = a_i;
              cnt_d    = '0;
              state_d  = S_FIX;
            end
          end else begin
            opnd_d   = w_a_mag;
            acc_lo_d = w_b_mag;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_b_mag == '0) begin
              cnt_d   = '0;
              state_d = S_FIX;
            end
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        cnt_d = w_cnt_next;
        if (is_div_q) begin
          acc_hi_d = w_div_rem;
          acc_lo_d = w_div_quo;
        end else begin
          acc_hi_d = w_mul_hi;
          acc_lo_d = w_mul_lo;
`ifdef MULDIV_EARLY_OUT_EN
          if (w_mul_early) begin
            {acc_hi_d, acc_lo_d} = w_mul_align;
            cnt_d                = '0;
            state_d              = S_FIX;
          end
`endif
        end
        if (cnt_q == c_cnt_one) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_DONE;
        if (dz_q) begin
          hi_d = acc_hi_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = w_rem_fix;
          lo_d = w_quo_fix;
        end else begin
          {hi_d, lo_d} = w_prod_fix;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a start in the same cycle, and
    // leaves the previously returned result visible.
    if (flush_i) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sign_lo_q <= 1'b0;
      sign_hi_q <= 1'b0;
      dz_q      <= 1'b0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sign_lo_q <= sign_lo_d;
      sign_hi_q <= sign_hi_d;
      dz_q      <= dz_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o     = (state_q == S_DONE);
  assign div_zero_o = (state_q == S_DONE) && dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_muldiv_iter
// Purpose  : Self-checking bench for pipe_muldiv_iter (WIDTH=32). A vector
//            table drives operations; expected HI/LO/div-zero, latency and
//            busy length are queued at issue and compared when done_o fires.
//            Hand-written sequences cover flush, reset, ignored start and
//            back-to-back issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_muldiv_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         div_zero_o;

  pipe_muldiv_iter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          acc_cyc;
    int          tag;
  } sb_t;

  sb_t         sb[$];
  sb_t         mon_e;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  int          busy_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference arithmetic, written with the simulator's own operators.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic [63:0] p;
    longint      sp;
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        p  = {32'd0, a} * {32'd0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p  = sp;
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1;
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          lo = a / b;
          hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'd0;
        end else begin
          lo = 32'($signed(a) / $signed(b));
          hi = 32'($signed(a) % $signed(b));
        end
      end
    endcase
  endfunction

  // Start-to-done latency in cycles (start cycle counted as 1).
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    m = b;
    if (op[1] && b == 32'd0) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!op[1]) begin
      if (op[0] && b[31]) m = -b;
      if (m == 32'd0) return 2;
      for (int i = 31; i >= 0; i--) if (m[i]) return i + 3;
    end
`endif
    return W + 2;
  endfunction

  // Scoreboard monitor: compares each done_o against the oldest queued entry.
  always @(negedge clk) begin
    if (busy_o) busy_run++;
    if (done_o) begin
      if (sb.size() == 0) begin
        check("unexpected done_o", {63'd0, done_o}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("v%0d hi", mon_e.tag), {32'd0, hi_o}, {32'd0, mon_e.hi});
        check($sformatf("v%0d lo", mon_e.tag), {32'd0, lo_o}, {32'd0, mon_e.lo});
        check($sformatf("v%0d div_zero", mon_e.tag), {63'd0, div_zero_o}, {63'd0, mon_e.dz});
        check($sformatf("v%0d latency", mon_e.tag), 64'(cyc - mon_e.acc_cyc + 1), 64'(mon_e.lat));
        check($sformatf("v%0d busy cycles", mon_e.tag), 64'(busy_run), 64'(mon_e.lat - 1));
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
      busy_run = 0;
    end else if (!busy_o) begin
      busy_run = 0;
    end
  end

  // Caller sits at a negedge with the DUT idle or in DONE.
  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                       input bit expect_done, input int tag);
    sb_t e;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    if (expect_done) begin
      e.hi      = hi;
      e.lo      = lo;
      e.dz      = dz;
      e.lat     = exp_lat(op, b);
      e.acc_cyc = cyc + 1;
      e.tag     = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("wait idle timeout", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain timeout", 64'(sb.size()), 64'd0);
  endtask

  vec_t vecs[17];

  initial begin
    logic [31:0] rhi, rlo;
    logic        rdz;
    int          n;

    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);

    check("reset busy_o", {63'd0, busy_o}, 64'd0);
    check("reset done_o", {63'd0, done_o}, 64'd0);
    check("reset div_zero_o", {63'd0, div_zero_o}, 64'd0);
    check("reset hi_o", {32'd0, hi_o}, 64'd0);
    check("reset lo_o", {32'd0, lo_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    //          op     a             b             hi            lo            dz
    vecs[0]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[5]  = '{2'b10, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[7]  = '{2'b00, 32'h1234_5678, 32'd3,         32'd0,         32'h369D_0368, 1'b0};
    vecs[8]  = '{2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd0,         32'd30,        1'b0};
    vecs[9]  = '{2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[10] = '{2'b00, 32'hDEAD_BEEF, 32'd0,         32'd0,         32'd0,         1'b0};
    for (int i = 11; i < 17; i++) begin
      vecs[i].op = 2'($urandom_range(0, 3));
      vecs[i].a  = $urandom;
      vecs[i].b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      model(vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, rdz);
      vecs[i].hi = rhi;
      vecs[i].lo = rlo;
      vecs[i].dz = rdz;
    end

    for (int i = 0; i < 17; i++) begin
      wait_not_busy();
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b1, i);
      wait_drain();
    end

    // Flush mid-MULTU: no done_o, previous result stays on hi_o/lo_o.
    @(negedge clk);
    drive(2'b00, 32'h0BAD_F00D, 32'h0001_2345, '0, '0, 1'b0, 1'b0, 100);
    repeat (8) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush busy_o", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);
    check("flush hi_o kept", {32'd0, hi_o}, {32'd0, last_hi});
    check("flush lo_o kept", {32'd0, lo_o}, {32'd0, last_lo});

    // Flush beats a simultaneous start.
    flush_i = 1'b1;
    drive(2'b10, 32'd50, 32'd3, '0, '0, 1'b0, 1'b0, 101);
    flush_i = 1'b0;
    check("flush over start busy_o", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset mid-DIV clears every output, no done_o afterwards.
    drive(2'b11, 32'h7654_3210, 32'd9, '0, '0, 1'b0, 1'b0, 102);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_hi = '0;
    last_lo = '0;
    check("rst busy_o", {63'd0, busy_o}, 64'd0);
    check("rst done_o", {63'd0, done_o}, 64'd0);
    check("rst div_zero_o", {63'd0, div_zero_o}, 64'd0);
    check("rst hi_o", {32'd0, hi_o}, 64'd0);
    check("rst lo_o", {32'd0, lo_o}, 64'd0);
    repeat (40) @(negedge clk);

    // start_i while busy is ignored: the first operation completes untouched.
    model(2'b10, 32'd1000, 32'd33, rhi, rlo, rdz);
    drive(2'b10, 32'd1000, 32'd33, rhi, rlo, rdz, 1'b1, 200);
    repeat (4) @(negedge clk);
    start_i = 1'b1; op_i = 2'b00; a_i = 32'd77; b_i = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);
    check("ignored start busy_o", {63'd0, busy_o}, 64'd0);

    // Back-to-back: start in the DONE cycle is accepted with no bubble.
    model(2'b01, 32'hFFFF_FF00, 32'd3, rhi, rlo, rdz);
    drive(2'b01, 32'hFFFF_FF00, 32'd3, rhi, rlo, rdz, 1'b1, 300);
    n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b first done seen", {63'd0, done_o}, 64'd1);
    model(2'b10, 32'hFFFF_FFFF, 32'd10, rhi, rlo, rdz);
    drive(2'b10, 32'hFFFF_FFFF, 32'd10, rhi, rlo, rdz, 1'b1, 301);
    wait_drain();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
